// File: rtl/target_select_rng.sv
// Random target picker: a free-running Galois LFSR feeds rejection sampling into 0..NUM_TARGETS-1.
// Score entropy is folded in at request time; an optional no-repeat rule applies to consecutive draws.
module target_select_rng #(
    parameter int unsigned      WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = 16'h0002,
    parameter int unsigned      NUM_TARGETS  = 10,
    parameter int unsigned      OUT_W        = 4,
    parameter bit               NO_REPEAT    = 1'b1,
    parameter int unsigned      MAX_TRIES    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic [31:0]      score,
    input  logic             req,
    output logic             busy,
    output logic             valid,
    output logic [OUT_W-1:0] target
);

    localparam int unsigned TryW = $clog2(MAX_TRIES + 1);
    localparam logic [TryW-1:0] LastTry = TryW'(MAX_TRIES - 1);
    // With a single target the no-repeat rule could never be satisfied.
    localparam bit NoRepeatEff = NO_REPEAT && (NUM_TARGETS > 1);

    typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] lfsr_q;
    logic [TryW-1:0]  tries_q;
    logic [OUT_W-1:0] target_q;
    logic             have_prev_q;
    logic             busy_q;
    logic             valid_q;

    logic [WIDTH-1:0] lfsr_step, lfsr_adv, lfsr_mix_raw, lfsr_mix, seed_nz;
    logic [OUT_W-1:0] cand, fallback;
    logic             cand_ok;

    always_comb begin
        lfsr_step    = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        lfsr_adv     = (lfsr_step == '0) ? WIDTH'(1) : lfsr_step;
        lfsr_mix_raw = lfsr_adv ^ score[WIDTH-1:0];
        lfsr_mix     = (lfsr_mix_raw == '0) ? WIDTH'(1) : lfsr_mix_raw;
        seed_nz      = (seed == '0) ? WIDTH'(1) : seed;

        cand    = lfsr_q[OUT_W-1:0];
        cand_ok = (32'(cand) < NUM_TARGETS) &&
                  !(NoRepeatEff && have_prev_q && (cand == target_q));

        if (!have_prev_q || (32'(target_q) == NUM_TARGETS - 1)) begin
            fallback = '0;
        end else begin
            fallback = target_q + OUT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            lfsr_q      <= SEED_DEFAULT;
            tries_q     <= '0;
            target_q    <= '0;
            have_prev_q <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            if (seed_load) begin
                lfsr_q <= seed_nz;
            end else if ((state_q == StIdle) && req) begin
                lfsr_q <= lfsr_mix;
            end else begin
                lfsr_q <= lfsr_adv;
            end

            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        state_q <= StDraw;
                        busy_q  <= 1'b1;
                        tries_q <= '0;
                    end
                end
                StDraw: begin
                    if (cand_ok) begin
                        target_q    <= cand;
                        have_prev_q <= 1'b1;
                        state_q     <= StDone;
                        valid_q     <= 1'b1;
                    end else if (tries_q == LastTry) begin
                        target_q    <= fallback;
                        have_prev_q <= 1'b1;
                        state_q     <= StDone;
                        valid_q     <= 1'b1;
                    end else begin
                        tries_q <= tries_q + TryW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign valid  = valid_q;
    assign target = target_q;

endmodule

// File: tb/tb_target_select_rng.sv
// Bench for target_select_rng: a transaction model predicts each draw at request time and a
// negedge monitor checks valid/target/busy against it; scenario tasks add direct checks.
module tb_target_select_rng;

    localparam int NT0 = 10;
    localparam int MT0 = 8;
    localparam int NT1 = 3;
    localparam int MT1 = 1;

    logic        clock = 1'b0;
    logic        reset, seed_load, req0, req1;
    logic [15:0] seed;
    logic [31:0] score;
    logic        busy0, valid0, busy1, valid1;
    logic [3:0]  target0, target1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clock = ~clock;

    target_select_rng u_dut0 (
        .clock(clock), .reset(reset), .seed_load(seed_load), .seed(seed), .score(score),
        .req(req0), .busy(busy0), .valid(valid0), .target(target0)
    );

    target_select_rng #(.NUM_TARGETS(NT1), .MAX_TRIES(MT1)) u_dut1 (
        .clock(clock), .reset(reset), .seed_load(seed_load), .seed(seed), .score(score),
        .req(req1), .busy(busy1), .valid(valid1), .target(target1)
    );

    function automatic logic [15:0] nz(input logic [15:0] v);
        return (v == 16'h0) ? 16'h1 : v;
    endfunction

    function automatic logic [15:0] gal(input logic [15:0] v);
        return nz({1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0));
    endfunction

    // Whole draw outcome from the LFSR value present in the first draw cycle.
    function automatic void draw(input logic [15:0] l0, input int nt, input int mt,
                                 input bit have, input int prev, output int tgt, output int k);
        logic [15:0] l;
        int c;
        bit norep;
        norep = (nt > 1);
        l = l0;
        for (int i = 1; i <= mt; i++) begin
            c = int'(l[3:0]);
            if (c < nt && !(norep && have && c == prev)) begin
                tgt = c;
                k = i;
                return;
            end
            l = gal(l);
        end
        tgt = have ? (prev + 1) % nt : 0;
        k = mt;
    endfunction

    typedef struct packed { int tgt; int at; } exp_t;
    exp_t sb0[$];
    exp_t sb1[$];
    logic [15:0] m_lfsr0, m_lfsr1;
    int m_free0 = 0, m_free1 = 0, m_prev0 = 0, m_prev1 = 0, m_hold0 = 0, m_hold1 = 0;
    bit m_have0 = 1'b0, m_have1 = 1'b0;

    always @(posedge clock) begin
        logic [15:0] nxt;
        int t, k;
        cyc = cyc + 1;
        if (reset) begin
            m_lfsr0 = 16'h0002; m_free0 = 0; m_have0 = 1'b0; m_prev0 = 0; m_hold0 = 0;
            m_lfsr1 = 16'h0002; m_free1 = 0; m_have1 = 1'b0; m_prev1 = 0; m_hold1 = 0;
            sb0.delete();
            sb1.delete();
        end else begin
            if (seed_load) nxt = nz(seed);
            else if (cyc > m_free0 && req0) nxt = nz(gal(m_lfsr0) ^ score[15:0]);
            else nxt = gal(m_lfsr0);
            if (cyc > m_free0 && req0) begin
                draw(nxt, NT0, MT0, m_have0, m_prev0, t, k);
                sb0.push_back('{tgt: t, at: cyc + k});
                m_free0 = cyc + k + 1; m_have0 = 1'b1; m_prev0 = t;
            end
            m_lfsr0 = nxt;

            if (seed_load) nxt = nz(seed);
            else if (cyc > m_free1 && req1) nxt = nz(gal(m_lfsr1) ^ score[15:0]);
            else nxt = gal(m_lfsr1);
            if (cyc > m_free1 && req1) begin
                draw(nxt, NT1, MT1, m_have1, m_prev1, t, k);
                sb1.push_back('{tgt: t, at: cyc + k});
                m_free1 = cyc + k + 1; m_have1 = 1'b1; m_prev1 = t;
            end
            m_lfsr1 = nxt;
        end
    end

    always @(negedge clock) begin
        bit ev;
        ev = (sb0.size() > 0) && (sb0[0].at == cyc);
        n_cmp++;
        if (valid0 !== ev) begin
            n_bad++;
            $display("FAIL sb_valid0 cyc %0d: got %b want %b", cyc, valid0, ev);
        end
        if (sb0.size() > 0 && sb0[0].at <= cyc) begin
            m_hold0 = sb0[0].tgt;
            void'(sb0.pop_front());
        end
        n_cmp++;
        if (target0 !== 4'(m_hold0)) begin
            n_bad++;
            $display("FAIL sb_target0 cyc %0d: got %0d want %0d", cyc, target0, m_hold0);
        end
        n_cmp++;
        if (busy0 !== (cyc < m_free0)) begin
            n_bad++;
            $display("FAIL sb_busy0 cyc %0d: got %b want %b", cyc, busy0, cyc < m_free0);
        end

        ev = (sb1.size() > 0) && (sb1[0].at == cyc);
        n_cmp++;
        if (valid1 !== ev) begin
            n_bad++;
            $display("FAIL sb_valid1 cyc %0d: got %b want %b", cyc, valid1, ev);
        end
        if (sb1.size() > 0 && sb1[0].at <= cyc) begin
            m_hold1 = sb1[0].tgt;
            void'(sb1.pop_front());
        end
        n_cmp++;
        if (target1 !== 4'(m_hold1)) begin
            n_bad++;
            $display("FAIL sb_target1 cyc %0d: got %0d want %0d", cyc, target1, m_hold1);
        end
        n_cmp++;
        if (busy1 !== (cyc < m_free1)) begin
            n_bad++;
            $display("FAIL sb_busy1 cyc %0d: got %b want %b", cyc, busy1, cyc < m_free1);
        end
    end

    // One request (optionally with a same-cycle seed load); returns the drawn target.
    task automatic pulse(input bit which, input bit load, input logic [15:0] sv,
                         output int t, output bit ok);
        @(negedge clock);
        if (load) begin
            seed_load = 1'b1;
            seed = sv;
        end
        if (which) req1 = 1'b1;
        else req0 = 1'b1;
        @(negedge clock);
        seed_load = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        ok = 1'b0;
        t = -1;
        for (int w = 0; w < 10 && !ok; w++) begin
            if ((which ? valid1 : valid0) === 1'b1) begin
                ok = 1'b1;
                t = which ? int'(target1) : int'(target0);
            end else begin
                @(negedge clock);
            end
        end
        @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (busy0 !== 1'b0 || valid0 !== 1'b0 || target0 !== 4'd0) begin
            n_bad++;
            $display("FAIL reset0: got busy=%b valid=%b target=%0d want 0/0/0",
                     busy0, valid0, target0);
        end
        n_cmp++;
        if (busy1 !== 1'b0 || valid1 !== 1'b0 || target1 !== 4'd0) begin
            n_bad++;
            $display("FAIL reset1: got busy=%b valid=%b target=%0d want 0/0/0",
                     busy1, valid1, target1);
        end
        reset = 1'b0;
    endtask

    task automatic test_single;
        int w;
        @(negedge clock);
        req0 = 1'b1;
        @(negedge clock);
        req0 = 1'b0;
        n_cmp++;
        if (busy0 !== 1'b1) begin
            n_bad++;
            $display("FAIL single_busy: got %b want 1", busy0);
        end
        w = 0;
        while (valid0 !== 1'b1 && w < MT0) begin
            @(negedge clock);
            w++;
        end
        n_cmp++;
        if (valid0 !== 1'b1) begin
            n_bad++;
            $display("FAIL single_latency: got no valid within %0d cycles want valid", MT0 + 1);
        end
        n_cmp++;
        if (!(target0 < 4'd10)) begin
            n_bad++;
            $display("FAIL single_range: got %0d want <10", target0);
        end
        @(negedge clock);
        n_cmp++;
        if (valid0 !== 1'b0 || busy0 !== 1'b0) begin
            n_bad++;
            $display("FAIL single_strobe: got valid=%b busy=%b want 0/0", valid0, busy0);
        end
    endtask

    task automatic test_back_to_back;
        int hist[10];
        int got, last, last_cyc, guard;
        for (int i = 0; i < 10; i++) hist[i] = 0;
        got = 0; last = -1; last_cyc = -100; guard = 0;
        @(negedge clock);
        req0 = 1'b1;
        while (got < 1000 && guard < 20000) begin
            @(negedge clock);
            guard++;
            score = $urandom;
            if (valid0 === 1'b1) begin
                if (last >= 0) begin
                    n_cmp++;
                    if (int'(target0) == last) begin
                        n_bad++;
                        $display("FAIL b2b_repeat draw %0d: got %0d want not %0d", got, target0, last);
                    end
                    n_cmp++;
                    if (cyc - last_cyc < 3) begin
                        n_bad++;
                        $display("FAIL b2b_spacing draw %0d: got %0d want >=3", got, cyc - last_cyc);
                    end
                end
                if (target0 < 4'd10) hist[int'(target0)]++;
                last = int'(target0);
                last_cyc = cyc;
                got++;
            end
        end
        req0 = 1'b0;
        score = 32'h0;
        n_cmp++;
        if (got != 1000) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d want 1000", got);
        end
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (hist[i] < 50) begin
                n_bad++;
                $display("FAIL b2b_hist[%0d]: got %0d want >=50", i, hist[i]);
            end
        end
        repeat (12) @(negedge clock);
    endtask

    task automatic test_reproducible;
        int a[8];
        int b[8];
        int t;
        bit ok;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clock);
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            seed = 16'h1234;
            score = 32'hCAFE_F00D;
            seed_load = 1'b1;
            @(negedge clock);
            seed_load = 1'b0;
            for (int i = 0; i < 8; i++) begin
                pulse(1'b0, 1'b0, 16'h0, t, ok);
                n_cmp++;
                if (!ok) begin
                    n_bad++;
                    $display("FAIL repro_timeout pass %0d draw %0d: got none want valid", pass, i);
                end
                if (pass == 0) a[i] = t;
                else b[i] = t;
            end
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (a[i] != b[i]) begin
                n_bad++;
                $display("FAIL repro[%0d]: got %0d want %0d", i, b[i], a[i]);
            end
        end
        score = 32'h0;
    endtask

    task automatic test_fallback;
        int t;
        bit ok;
        logic [15:0] seeds[5];
        int want[5];
        seeds = '{16'h0000, 16'h000F, 16'h0002, 16'h0000, 16'h000E};
        want  = '{1, 2, 0, 1, 0};
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
            end
            pulse(1'b1, 1'b1, seeds[i], t, ok);
            n_cmp++;
            if (!ok || t != want[i]) begin
                n_bad++;
                $display("FAIL fallback[%0d]: got %0d (ok=%b) want %0d", i, t, ok, want[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            score = $urandom;
            pulse(1'b1, 1'b0, 16'h0, t, ok);
            n_cmp++;
            if (!ok || t < 0 || t >= NT1) begin
                n_bad++;
                $display("FAIL fallback_rand[%0d]: got %0d (ok=%b) want 0..2", i, t, ok);
            end
        end
        score = 32'h0;
    endtask

    task automatic test_reset_mid_draw;
        int t;
        bit ok;
        @(negedge clock);
        req0 = 1'b1;
        @(negedge clock);
        req0 = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_cmp++;
        if (busy0 !== 1'b0 || valid0 !== 1'b0 || target0 !== 4'd0) begin
            n_bad++;
            $display("FAIL mid_reset: got busy=%b valid=%b target=%0d want 0/0/0",
                     busy0, valid0, target0);
        end
        score = 32'h0;
        for (int i = 0; i < 10; i++) begin
            pulse(1'b0, 1'b0, 16'h0, t, ok);
            n_cmp++;
            if (!ok || t < 0 || t >= NT0) begin
                n_bad++;
                $display("FAIL score0[%0d]: got %0d (ok=%b) want 0..9", i, t, ok);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        seed_load = 1'b0;
        seed = 16'h0;
        score = 32'h0;
        req0 = 1'b0;
        req1 = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_reproducible();
        test_fallback();
        test_reset_mid_draw();
        repeat (4) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
